// File: rtl/data_memory_ctrl_if.sv
// Request/response bus of the RV32 data memory.
// Handshake: a request is accepted on a rising edge where req_valid_in & req_ready_out;
// the master holds all request fields stable while req_valid_in is high, and the
// response (resp_valid_out pulse with read_data_out/fault_out) appears one cycle later.
interface data_memory_ctrl_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  en_data_mem;
  logic                  req_valid_in;
  logic                  req_ready_out;
  logic                  write_en_in;
  logic [2:0]            funct3_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [31:0]           write_data_in;
  logic                  resp_valid_out;
  logic [31:0]           read_data_out;
  logic                  fault_out;

  modport slave (
    input  en_data_mem, req_valid_in, write_en_in, funct3_in, addr_in, write_data_in,
    output req_ready_out, resp_valid_out, read_data_out, fault_out
  );

  modport master (
    output en_data_mem, req_valid_in, write_en_in, funct3_in, addr_in, write_data_in,
    input  req_ready_out, resp_valid_out, read_data_out, fault_out
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Word-organised byte-lane data RAM executing RV32 loads/stores with a registered response.
// Optional post-reset zeroing sweep enabled by defining DMEM_CLEAR_ON_RESET_EN.
module data_memory_ctrl #(
  parameter int    DEPTH      = 32,
  parameter int    ADDR_WIDTH = 7,
  parameter string INIT_FILE  = ""
) (
  input  logic                Clock,
  input  logic                reset_n,
  data_memory_ctrl_if.slave   bus,
  output logic                state_dbg
);
  localparam int WORD_W = ADDR_WIDTH - 2;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t state, state_nxt;
  logic [31:0] mem [DEPTH];

  logic              clr_we;
  logic [WORD_W-1:0] clr_idx;

`ifdef DMEM_CLEAR_ON_RESET_EN
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_idx <= clr_idx + WORD_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_idx == WORD_W'(DEPTH - 1)) state_nxt = ST_READY;
  end

  assign clr_we = (state == ST_CLEAR) & reset_n;
`else
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) state <= ST_READY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
  end

  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  assign state_dbg         = (state == ST_READY);
  assign bus.req_ready_out = (state == ST_READY) & bus.en_data_mem & reset_n;

  logic              accept;
  logic [WORD_W-1:0] word_idx;
  logic [1:0]        offset;
  logic              size_b, size_h, size_w, illegal, misaligned, req_fault, st_we;
  logic [3:0]        lane_en;
  logic [31:0]       st_data, rd_word, rd_shift, load_val;

  assign accept   = bus.req_valid_in & bus.req_ready_out;
  assign word_idx = bus.addr_in[ADDR_WIDTH-1:2];
  assign offset   = bus.addr_in[1:0];

  always_comb begin
    size_b     = (bus.funct3_in[1:0] == 2'b00);
    size_h     = (bus.funct3_in[1:0] == 2'b01);
    size_w     = (bus.funct3_in == 3'b010);
    // Stores have no unsigned variants, so funct3[2] is illegal for them.
    illegal    = !(size_b || size_h || size_w) || (bus.write_en_in && bus.funct3_in[2]);
    misaligned = (size_h && offset[0]) || (size_w && offset != 2'b00);
    req_fault  = illegal || misaligned;
    st_we      = accept && bus.write_en_in && !req_fault;

    lane_en = 4'b1111;
    st_data = bus.write_data_in;
    if (size_b) begin
      lane_en = 4'b0001 << offset;
      st_data = {4{bus.write_data_in[7:0]}};
    end else if (size_h) begin
      lane_en = 4'b0011 << offset;
      st_data = {2{bus.write_data_in[15:0]}};
    end

    rd_word  = mem[word_idx];
    rd_shift = rd_word >> {offset, 3'b000};
    case (bus.funct3_in)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_val = {24'd0, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_val = {16'd0, rd_shift[15:0]};
      3'b010:  load_val = rd_shift;
      default: load_val = 32'd0;
    endcase
  end

  // The array itself is never reset so its contents survive reset_n.
  always_ff @(posedge Clock) begin
    if (clr_we) begin
      mem[clr_idx] <= 32'd0;
    end else if (st_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.resp_valid_out <= 1'b0;
      bus.read_data_out  <= 32'd0;
      bus.fault_out      <= 1'b0;
    end else begin
      bus.resp_valid_out <= accept;
      if (accept) begin
        bus.fault_out     <= req_fault;
        bus.read_data_out <= (req_fault || bus.write_en_in) ? 32'd0 : load_val;
      end
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl against a byte-array model of RV32 loads/stores.
// Works with or without DMEM_CLEAR_ON_RESET_EN defined.
module tb_data_memory_ctrl;
  localparam int DEPTH = 32;
  localparam int AW    = 7;

  logic Clock = 1'b0;
  logic reset_n = 1'b0;
  logic state_dbg;
  always #5 Clock = ~Clock;

  data_memory_ctrl_if #(.ADDR_WIDTH(AW)) dmem ();

  data_memory_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INIT_FILE("")) dut (
    .Clock     (Clock),
    .reset_n   (reset_n),
    .bus       (dmem.slave),
    .state_dbg (state_dbg)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  mb [DEPTH*4];
  logic [31:0] last_data = 32'd0;
  logic        last_fault = 1'b0;
  bit          ready_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory as bytes; an access covers sz consecutive bytes, little-endian.
  task automatic model(input bit we, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [31:0] wd, output logic [31:0] d, output logic f);
    int sz, ai;
    bit legal, sgn;
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    legal = (sz != 0) && !(we && f3 >= 3'd4);
    sgn   = (f3 < 3'd4);
    ai    = int'(a);
    d = 32'd0;
    f = 1'b0;
    if (!legal) f = 1'b1;
    else if (ai % sz != 0) f = 1'b1;
    else if (we) begin
      for (int i = 0; i < sz; i++) mb[ai + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[ai + i];
      if (sgn && sz < 4 && v[8*sz - 1]) for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
      d = v;
    end
  endtask

  // Called at a falling edge; drives one cycle of request and checks its response.
  task automatic step(input bit en, input bit v, input bit we, input logic [2:0] f3,
                      input logic [AW-1:0] a, input logic [31:0] wd);
    bit acc;
    logic [31:0] ed;
    logic ef;
    dmem.en_data_mem   = en;
    dmem.req_valid_in  = v;
    dmem.write_en_in   = we;
    dmem.funct3_in     = f3;
    dmem.addr_in       = a;
    dmem.write_data_in = wd;
    #1;
    chk("ready", 32'(dmem.req_ready_out), 32'(ready_m & en));
    acc = v & ready_m & en;
    if (acc) begin
      model(we, f3, a, wd, ed, ef);
      last_data  = ed;
      last_fault = ef;
    end
    @(posedge Clock);
    @(negedge Clock);
    chk("resp_valid", 32'(dmem.resp_valid_out), 32'(acc));
    chk("read_data", dmem.read_data_out, last_data);
    chk("fault", 32'(dmem.fault_out), 32'(last_fault));
    dmem.req_valid_in = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(dmem.req_ready_out), 32'd0);
    chk({tag, "_rvalid"}, 32'(dmem.resp_valid_out), 32'd0);
    chk({tag, "_rdata"}, dmem.read_data_out, 32'd0);
    chk({tag, "_fault"}, 32'(dmem.fault_out), 32'd0);
    last_data  = 32'd0;
    last_fault = 1'b0;
  endtask

  // Called at a falling edge just after reset_n rises.
  task automatic after_release();
`ifdef DMEM_CLEAR_ON_RESET_EN
    ready_m = 1'b0;
    #1 chk("sweep_ready0", 32'(dmem.req_ready_out), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      @(negedge Clock);
      chk("sweep_ready", 32'(dmem.req_ready_out), 32'd0);
    end
    @(negedge Clock);
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    ready_m = 1'b1;
`else
    ready_m = 1'b1;
`endif
  endtask

  logic [31:0] ed;
  logic        ef;

  initial begin
    dmem.en_data_mem   = 1'b1;
    dmem.req_valid_in  = 1'b0;
    dmem.write_en_in   = 1'b0;
    dmem.funct3_in     = 3'd0;
    dmem.addr_in       = '0;
    dmem.write_data_in = 32'd0;
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'hxx;

    repeat (3) @(negedge Clock);
    #1 chk_reset_outputs("reset");
    @(negedge Clock);
    reset_n = 1'b1;
    after_release();

`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int w = 0; w < DEPTH; w++) step(1, 1, 0, 3'd2, AW'(w*4), 32'd0);
    chk("sweep_zero_const", dmem.read_data_out, 32'h0);
`else
    for (int w = 0; w < DEPTH; w++) step(1, 1, 1, 3'd2, AW'(w*4), $urandom);
`endif

    // Directed stores and sub-word loads
    step(1, 1, 1, 3'd2, 7'h08, 32'h11223344);
    step(1, 1, 1, 3'd0, 7'h09, 32'h000000AA);
    step(1, 1, 0, 3'd2, 7'h08, 32'h0);
    chk("lw08_const", dmem.read_data_out, 32'h1122AA44);
    step(1, 1, 1, 3'd1, 7'h0A, 32'h00008899);
    step(1, 1, 0, 3'd0, 7'h0A, 32'h0);
    chk("lb_const", dmem.read_data_out, 32'hFFFFFF99);
    step(1, 1, 0, 3'd4, 7'h0A, 32'h0);
    chk("lbu_const", dmem.read_data_out, 32'h00000099);
    step(1, 1, 0, 3'd1, 7'h0A, 32'h0);
    chk("lh_const", dmem.read_data_out, 32'hFFFF8899);
    step(1, 1, 0, 3'd5, 7'h0A, 32'h0);
    chk("lhu_const", dmem.read_data_out, 32'h00008899);

    // Faults
    step(1, 1, 0, 3'd2, 7'h05, 32'h0);
    chk("lw_mis_fault", 32'(dmem.fault_out), 32'd1);
    step(1, 1, 1, 3'd1, 7'h03, 32'h0000BEEF);
    chk("sh_mis_fault", 32'(dmem.fault_out), 32'd1);
    step(1, 1, 0, 3'd2, 7'h00, 32'h0);
    step(1, 1, 0, 3'd3, 7'h04, 32'h0);
    chk("f3_011_fault", 32'(dmem.fault_out), 32'd1);
    step(1, 1, 1, 3'd4, 7'h04, 32'h12345678);
    step(1, 1, 0, 3'd6, 7'h04, 32'h0);
    step(1, 1, 0, 3'd7, 7'h04, 32'h0);
    step(1, 1, 0, 3'd2, 7'h04, 32'h0);

    // Back-to-back stream
    step(1, 1, 1, 3'd2, 7'h10, 32'hCAFEF00D);
    step(1, 1, 0, 3'd2, 7'h10, 32'h0);
    chk("b2b_const", dmem.read_data_out, 32'hCAFEF00D);
    step(1, 1, 0, 3'd2, 7'h14, 32'h0);
    step(1, 1, 1, 3'd2, 7'h14, 32'h0BADBEEF);
    step(1, 0, 0, 3'd2, 7'h14, 32'h0);

    // Disabled block ignores a request; outputs hold
    step(0, 1, 1, 3'd2, 7'h10, 32'hDEADDEAD);
    step(1, 1, 0, 3'd2, 7'h10, 32'h0);

    // Enable drops after acceptance: the response still arrives
    model(0, 3'd2, 7'h14, 32'h0, ed, ef);
    dmem.req_valid_in = 1'b1; dmem.write_en_in = 1'b0; dmem.funct3_in = 3'd2;
    dmem.addr_in = 7'h14;
    @(posedge Clock);
    #1 dmem.en_data_mem = 1'b0; dmem.req_valid_in = 1'b0;
    @(negedge Clock);
    chk("endrop_valid", 32'(dmem.resp_valid_out), 32'd1);
    chk("endrop_data", dmem.read_data_out, ed);
    last_data = ed; last_fault = ef;
    dmem.en_data_mem = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           3'($urandom_range(0, 7)), AW'($urandom_range(0, DEPTH*4 - 1)), $urandom);
    end

    // Reset mid-access: the pending response is dropped asynchronously
    dmem.en_data_mem = 1'b1; dmem.req_valid_in = 1'b1; dmem.write_en_in = 1'b0;
    dmem.funct3_in = 3'd2; dmem.addr_in = 7'h10;
    @(posedge Clock);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    dmem.req_valid_in = 1'b0;
    @(negedge Clock);
    reset_n = 1'b1;
`ifdef DMEM_CLEAR_ON_RESET_EN
    // Interrupt the sweep and check it restarts from the beginning
    ready_m = 1'b0;
    repeat (10) @(negedge Clock);
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("sweepreset");
    @(negedge Clock);
    reset_n = 1'b1;
`endif
    after_release();
    step(1, 1, 0, 3'd2, 7'h10, 32'h0);
    step(1, 1, 0, 3'd2, 7'h08, 32'h0);
    step(1, 1, 0, 3'd2, AW'((DEPTH - 1) * 4), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
